// File: rtl/regwb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter: FSM states,
// the "no requester" grant code, sweep bounds and the round-robin successor.
package regwb_arbiter_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_INIT = 1'b1
  } state_t;

  localparam logic [1:0] GNT_NONE    = 2'd3;
  localparam int         SWEEP_FIRST = 1;
  localparam int         SWEEP_LAST  = 31;

  // Pointer successor over three requesters: 0 -> 1 -> 2 -> 0.
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/regwb_arbiter_rr_pick3.sv
// Three-way round-robin picker: the first valid requester at or after the
// pointer wins. Purely combinational.
module rr_pick3 (
  input  logic [2:0] i_valid,
  input  logic [1:0] i_ptr,
  output logic [2:0] o_gnt,
  output logic [1:0] o_idx
);

  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    o_gnt = 3'b000;
    case (i_ptr)
      2'd1: begin
        if      (i_valid[1]) o_gnt = 3'b010;
        else if (i_valid[2]) o_gnt = 3'b100;
        else if (i_valid[0]) o_gnt = 3'b001;
      end
      2'd2: begin
        if      (i_valid[2]) o_gnt = 3'b100;
        else if (i_valid[0]) o_gnt = 3'b001;
        else if (i_valid[1]) o_gnt = 3'b010;
      end
      default: begin
        if      (i_valid[0]) o_gnt = 3'b001;
        else if (i_valid[1]) o_gnt = 3'b010;
        else if (i_valid[2]) o_gnt = 3'b100;
      end
    endcase
    o_idx = {o_gnt[2], o_gnt[1]};
  end

endmodule

// File: rtl/regwb_arbiter.sv
// Register-file writeback arbiter: round-robin merge of three write ports
// with a one-cycle registered output, plus a zero sweep of registers 1..31.
module regwb_arbiter
  import regwb_arbiter_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int DW   = 32,
  parameter int AW   = 5
) (
  input  logic                 clk,
  input  logic                 clrn,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_wn,
  input  logic [NREQ*DW-1:0]   req_d,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 init_start,
  output logic                 rf_we,
  output logic [AW-1:0]        rf_wn,
  output logic [DW-1:0]        rf_d,
  output logic [1:0]           gnt_id,
  output logic                 busy
);

  state_t          r_state, w_state_nxt;
  logic [1:0]      r_ptr, w_ptr_nxt;
  logic [AW-1:0]   r_cnt, w_cnt_nxt;
  logic            r_we, w_we_nxt;
  logic [AW-1:0]   r_wn, w_wn_nxt;
  logic [DW-1:0]   r_d, w_d_nxt;
  logic [1:0]      r_gnt, w_gnt_nxt;

  logic [2:0]      w_pick_gnt;
  logic [1:0]      w_pick_idx;
  logic [NREQ-1:0] w_ready;
  logic            w_xfer;
  logic [AW-1:0]   w_sel_wn;
  logic [DW-1:0]   w_sel_d;

  rr_pick3 u_pick (
    .i_valid (req_valid),
    .i_ptr   (r_ptr),
    .o_gnt   (w_pick_gnt),
    .o_idx   (w_pick_idx)
  );

  // Ready is held low while reset is asserted, even though valid may be high.
  assign w_ready   = (r_state == ST_RUN && !clrn) ? w_pick_gnt : '0;
  assign w_xfer    = |(req_valid & w_ready);
  assign req_ready = w_ready;

  always_comb begin
    w_sel_wn = '0;
    w_sel_d  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_ready[i]) begin
        w_sel_wn = req_wn[i*AW +: AW];
        w_sel_d  = req_d[i*DW +: DW];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_we_nxt    = 1'b0;
    w_wn_nxt    = r_wn;
    w_d_nxt     = r_d;
    w_gnt_nxt   = GNT_NONE;
    case (r_state)
      ST_RUN: begin
        if (w_xfer) begin
          // Writes to register 0 are consumed but never reach the register file.
          w_we_nxt  = (w_sel_wn != '0);
          w_wn_nxt  = w_sel_wn;
          w_d_nxt   = w_sel_d;
          w_gnt_nxt = w_pick_idx;
          w_ptr_nxt = rr_next(w_pick_idx);
        end
        if (init_start) begin
          w_state_nxt = ST_INIT;
          w_cnt_nxt   = AW'(SWEEP_FIRST);
        end
      end
      ST_INIT: begin
        w_we_nxt = 1'b1;
        w_wn_nxt = r_cnt;
        w_d_nxt  = '0;
        if (r_cnt == AW'(SWEEP_LAST)) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = AW'(SWEEP_FIRST);
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      r_state <= ST_RUN;
      r_ptr   <= 2'd0;
      r_cnt   <= AW'(SWEEP_FIRST);
      r_we    <= 1'b0;
      r_wn    <= '0;
      r_d     <= '0;
      r_gnt   <= GNT_NONE;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_we    <= w_we_nxt;
      r_wn    <= w_wn_nxt;
      r_d     <= w_d_nxt;
      r_gnt   <= w_gnt_nxt;
    end
  end

  assign rf_we  = r_we;
  assign rf_wn  = r_wn;
  assign rf_d   = r_d;
  assign gnt_id = r_gnt;
  assign busy   = (r_state == ST_INIT);

endmodule
